// File: rtl/maindec_pipe.sv
// RV32I main decoder registered into the ID/EX boundary, with a FENCE drain FSM.
// Define MAINDEC_TRAP_EN to add the sticky TrapReqE / TrapAck illegal-opcode trap handshake.
module maindec_pipe #(
  parameter int unsigned DRAIN_CYCLES = 3  // must be >= 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opD,
  input  logic       StallD,
  input  logic       FlushD,
  input  logic       StallE,
  input  logic       FlushE,
`ifdef MAINDEC_TRAP_EN
  input  logic       TrapAck,
  output logic       TrapReqE,
`endif
  output logic [2:0] ImmSrcD,
  output logic       DrainStallD,
  output logic       RegWriteE,
  output logic [1:0] ResultSrcE,
  output logic       MemWriteE,
  output logic       BranchE,
  output logic       JumpE,
  output logic       JalrE,
  output logic       ALUSrcAE,
  output logic       ALUSrcBE,
  output logic [1:0] ALUOpE,
  output logic       IllegalE
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpFence  = 7'b0001111;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StDrain   = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  ctrl_t            dec;
  ctrl_t            e_d, e_q;
  logic [1:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             trap_active;
  logic             bubble;
  logic             load_dec;

  // Unknown opcodes fall to the default arm: a zero word with only the illegal flag set.
  always_comb begin
    dec     = '0;
    ImmSrcD = 3'b000;
    case (opD)
      OpLoad: begin
        dec.reg_write  = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.result_src = 2'b01;
      end
      OpStore: begin
        ImmSrcD       = 3'b001;
        dec.alu_src_b = 1'b1;
        dec.mem_write = 1'b1;
      end
      OpReg: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
      end
      OpBranch: begin
        ImmSrcD    = 3'b010;
        dec.branch = 1'b1;
        dec.alu_op = 2'b01;
      end
      OpImm: begin
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_op    = 2'b10;
      end
      OpJal: begin
        ImmSrcD        = 3'b011;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
      end
      OpJalr: begin
        dec.reg_write  = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.result_src = 2'b10;
        dec.jalr       = 1'b1;
      end
      OpLui: begin
        ImmSrcD        = 3'b100;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b11;
      end
      OpAuipc: begin
        ImmSrcD       = 3'b100;
        dec.reg_write = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
      end
      OpFence: ;
      default: dec.illegal = 1'b1;
    endcase
  end

  // Drain FSM: the counter runs regardless of StallD so the hold length is fixed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (opD == OpFence && !StallD && !FlushD && !trap_active) begin
          state_d = StDrain;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      StDrain: begin
        if (FlushD) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StRelease: begin
        if (!StallE) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign bubble      = FlushD || (state_q == StDrain) || trap_active;
  assign load_dec    = !FlushE && !StallE && !bubble;
  assign DrainStallD = (state_q == StDrain) || trap_active;

  always_comb begin
    e_d = e_q;
    if (FlushE) begin
      e_d = '0;
    end else if (!StallE) begin
      e_d = bubble ? '0 : dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      e_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
    end
  end

`ifdef MAINDEC_TRAP_EN
  logic trap_d, trap_q;

  // Acknowledge beats a fresh illegal opcode arriving in the same cycle.
  always_comb begin
    trap_d = trap_q | (load_dec & dec.illegal);
    if (TrapAck) trap_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign trap_active = trap_q;
  assign TrapReqE    = trap_q;
`else
  assign trap_active = 1'b0;
`endif

  assign RegWriteE  = e_q.reg_write;
  assign ResultSrcE = e_q.result_src;
  assign MemWriteE  = e_q.mem_write;
  assign BranchE    = e_q.branch;
  assign JumpE      = e_q.jump;
  assign JalrE      = e_q.jalr;
  assign ALUSrcAE   = e_q.alu_src_a;
  assign ALUSrcBE   = e_q.alu_src_b;
  assign ALUOpE     = e_q.alu_op;
  assign IllegalE   = e_q.illegal;

endmodule

// File: tb/tb_maindec_pipe.sv
// Scoreboard bench for maindec_pipe: a driver pushes predicted responses, a monitor compares.
// Builds with or without MAINDEC_TRAP_EN.
module tb_maindec_pipe;

  localparam int unsigned DRAIN_CYCLES = 3;
  localparam logic [6:0]  FENCE        = 7'b0001111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opD;
  logic       StallD, FlushD, StallE, FlushE;
  logic [2:0] ImmSrcD;
  logic       DrainStallD, RegWriteE, MemWriteE, BranchE, JumpE, JalrE;
  logic       ALUSrcAE, ALUSrcBE, IllegalE;
  logic [1:0] ResultSrcE, ALUOpE;
`ifdef MAINDEC_TRAP_EN
  logic       TrapAck, TrapReqE;
`endif

  maindec_pipe #(.DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk        (clk),
    .reset      (reset),
    .opD        (opD),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .StallE     (StallE),
    .FlushE     (FlushE),
`ifdef MAINDEC_TRAP_EN
    .TrapAck    (TrapAck),
    .TrapReqE   (TrapReqE),
`endif
    .ImmSrcD    (ImmSrcD),
    .DrainStallD(DrainStallD),
    .RegWriteE  (RegWriteE),
    .ResultSrcE (ResultSrcE),
    .MemWriteE  (MemWriteE),
    .BranchE    (BranchE),
    .JumpE      (JumpE),
    .JalrE      (JalrE),
    .ALUSrcAE   (ALUSrcAE),
    .ALUSrcBE   (ALUSrcBE),
    .ALUOpE     (ALUOpE),
    .IllegalE   (IllegalE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] word;
    logic        ill;
    logic        drain;
    logic [2:0]  imm;
    logic        trap;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic [13:0] m_e = '0;
  logic        m_ill = 1'b0;
  int          m_drain_left = 0;
  logic        m_release = 1'b0;
  logic        m_trap = 1'b0;

  logic [6:0] op_list [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Row in table column order: RegWrite, ImmSrc[3], ALUSrcA, ALUSrcB, MemWrite,
  // ResultSrc[2], Branch, ALUOp[2], Jump, Jalr.
  function automatic logic [13:0] spec_row(input logic [6:0] op, output logic ill);
    ill = 1'b0;
    case (op)
      7'b0000011: return 14'b1_000_0_1_0_01_0_00_0_0;
      7'b0100011: return 14'b0_001_0_1_1_00_0_00_0_0;
      7'b0110011: return 14'b1_000_0_0_0_00_0_10_0_0;
      7'b1100011: return 14'b0_010_0_0_0_00_1_01_0_0;
      7'b0010011: return 14'b1_000_0_1_0_00_0_10_0_0;
      7'b1101111: return 14'b1_011_0_0_0_10_0_00_1_0;
      7'b1100111: return 14'b1_000_0_1_0_10_0_00_0_1;
      7'b0110111: return 14'b1_100_0_0_0_11_0_00_0_0;
      7'b0010111: return 14'b1_100_1_1_0_00_0_00_0_0;
      7'b0001111: return 14'b0;
      default: begin
        ill = 1'b1;
        return 14'b0;
      end
    endcase
  endfunction

  function automatic logic [13:0] actual_e();
    return {RegWriteE, 3'b000, ALUSrcAE, ALUSrcBE, MemWriteE, ResultSrcE, BranchE, ALUOpE,
            JumpE, JalrE};
  endfunction

  // Advance the model across one rising edge using the inputs the DUT just sampled.
  task automatic model_step();
    logic        draining, trap_now, bub, ill;
    logic [13:0] row;
    draining = (m_drain_left > 0);
    trap_now = m_trap;
    bub      = FlushD || draining || trap_now;
    row      = spec_row(opD, ill);
    if (FlushE) begin
      m_e = '0; m_ill = 1'b0;
    end else if (!StallE) begin
      m_e   = bub ? 14'b0 : (row & ~14'h1C00);
      m_ill = bub ? 1'b0 : ill;
    end
`ifdef MAINDEC_TRAP_EN
    if (TrapAck) m_trap = 1'b0;
    else if (!FlushE && !StallE && !bub && ill) m_trap = 1'b1;
`endif
    if (draining) begin
      if (FlushD) begin
        m_drain_left = 0;
      end else begin
        m_drain_left--;
        if (m_drain_left == 0) m_release = 1'b1;
      end
    end else if (m_release) begin
      if (!StallE) m_release = 1'b0;
    end else if (opD == FENCE && !StallD && !FlushD && !trap_now) begin
      m_drain_left = DRAIN_CYCLES;
    end
  endtask

  task automatic cycle(input logic [6:0] op, input logic sd, input logic fd, input logic se,
                       input logic fe, input logic ack);
    exp_t        e;
    logic        ill;
    logic [13:0] row;
    @(posedge clk);
    model_step();
    #2;
    opD = op; StallD = sd; FlushD = fd; StallE = se; FlushE = fe;
`ifdef MAINDEC_TRAP_EN
    TrapAck = ack;
`else
    if (ack) ;
`endif
    row     = spec_row(op, ill);
    e.word  = m_e;
    e.ill   = m_ill;
    e.drain = (m_drain_left > 0) || m_trap;
    e.imm   = row[12:10];
    e.trap  = m_trap;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("e_word", 32'(actual_e()), 32'(e.word));
        check("illegal_e", 32'(IllegalE), 32'(e.ill));
        check("drain_stall", 32'(DrainStallD), 32'(e.drain));
        check("imm_src", 32'(ImmSrcD), 32'(e.imm));
`ifdef MAINDEC_TRAP_EN
        check("trap_req", 32'(TrapReqE), 32'(e.trap));
`endif
      end
    end
  end

  function automatic logic [6:0] rand_op();
    int unsigned k = $urandom_range(0, 13);
    if (k < 10) return op_list[k];
    if (k < 12) return FENCE;
    return 7'($urandom);
  endfunction

  initial begin : driver
    reset = 1'b1;
    opD = 7'b0110011; StallD = 0; FlushD = 0; StallE = 0; FlushE = 0;
`ifdef MAINDEC_TRAP_EN
    TrapAck = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_e_word", 32'(actual_e()), 32'h0);
    check("reset_illegal", 32'(IllegalE), 32'h0);
    check("reset_drain", 32'(DrainStallD), 32'h0);
    reset = 1'b0;

    foreach (op_list[i]) cycle(op_list[i], 0, 0, 0, 0, 0);
    repeat (7) cycle(FENCE, 0, 0, 0, 0, 0);
    cycle(7'b0110011, 0, 0, 0, 0, 0);
    cycle(7'b0110011, 0, 0, 0, 0, 0);
    // Abort a drain with FlushD in its second cycle.
    cycle(FENCE, 0, 0, 0, 0, 0);
    cycle(FENCE, 0, 0, 0, 0, 0);
    cycle(FENCE, 0, 1, 0, 0, 0);
    cycle(7'b0110011, 0, 0, 0, 0, 0);
    cycle(7'b0110111, 0, 0, 0, 0, 0);
    cycle(7'b1101111, 0, 0, 1, 0, 0);
    cycle(7'b1101111, 0, 0, 1, 1, 0);
    cycle(7'b0010011, 0, 0, 0, 0, 0);
    cycle(7'b1111111, 0, 0, 0, 0, 0);
    repeat (3) cycle(7'b0110011, 0, 0, 0, 0, 0);
    cycle(7'b0110011, 0, 0, 0, 0, 1);
    cycle(7'b0110011, 0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      cycle(rand_op(), $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 30);
    end
    repeat (DRAIN_CYCLES + 3) cycle(7'b0110011, 0, 0, 0, 0, 1);
    cycle(7'b0110011, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    // Asynchronous reset mid-drain with a live word held in E.
    @(posedge clk); #2;
    opD = 7'b0110111;
    @(posedge clk); #2;
    opD = FENCE; StallE = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_reset_drain", 32'(DrainStallD), 32'h1);
    check("pre_reset_e_word", 32'(actual_e()), 32'(14'b1_000_0_0_0_11_0_00_0_0));
    #1 reset = 1'b1;
    #1;
    check("async_reset_drain", 32'(DrainStallD), 32'h0);
    check("async_reset_e_word", 32'(actual_e()), 32'h0);
    check("async_reset_illegal", 32'(IllegalE), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    StallE = 1'b0;
    opD = 7'b0110011;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
